// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse receiver: run-length classification and letter decode
//
// Purpose: samples a mark/space stream, measures high and low runs in
// clock cycles, collects dots and dashes, and decodes each letter into
// its 3-bit code (Q..X) when a letter gap is seen.
//
// Ports:
//   CLOCK_50     in   1  sole clock, all logic on posedge
//   reset        in   1  synchronous active-high reset
//   morse_in     in   1  serial Morse, 1 = mark
//   letter       out  3  last decoded letter code (Q=000 .. X=111)
//   letter_valid out  1  one-cycle pulse when letter/letter_err update
//   letter_err   out  1  last letter malformed or unmatched
//   busy         out  1  high while a letter is being received

module morse_decoder #(
  parameter int UNIT_CYCLES = 25000000,
  parameter int GAP_UNITS   = 3,
  parameter int CNT_W       = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(4 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_UNITS * UNIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             s;
  logic             s_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bits;
  logic [2:0]       sym_cnt;
  logic             err;
  logic             clear_pat;
  logic             shift_en;
  logic             set_err;
  logic [2:0]       dec_letter;
  logic             dec_ok;

  // Two-flop synchroniser, plus one extra delayed copy used only to spot
  // run boundaries. The FSM and the counter both see a boundary on the same
  // edge, so the counter still holds the finished run length when the FSM
  // classifies it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= morse_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  // Run-length counter: restarts at 1 on a boundary, saturates so a stuck
  // input cannot wrap around into a plausible length.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt <= '0;
    end else if (s != s_d) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear_pat  = 1'b0;
    shift_en   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = MARK;
          clear_pat  = 1'b1;
        end
      end
      MARK: begin
        if (!s) begin
          state_next = SPACE;
          if (cnt > DASH_MAX) begin
            set_err = 1'b1;
          end else if (sym_cnt == 3'd4) begin
            set_err = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      SPACE: begin
        if (s) begin
          state_next = MARK;
        end else if (cnt >= GAP_LEN) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        // A mark arriving now is picked up from IDLE on the next cycle.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Symbols enter at the LSB so a short pattern stays right-aligned and the
  // first symbol ends up in the most significant used position.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear_pat) begin
      bits    <= 4'b0000;
      sym_cnt <= 3'd0;
      err     <= 1'b0;
    end else begin
      if (shift_en) begin
        bits    <= {bits[2:0], (cnt >= DASH_MIN)};
        sym_cnt <= sym_cnt + 3'd1;
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    dec_letter = 3'b000;
    dec_ok     = 1'b1;
    case ({sym_cnt, bits})
      {3'd4, 4'b1101}: dec_letter = 3'b000;
      {3'd3, 4'b0010}: dec_letter = 3'b001;
      {3'd3, 4'b0000}: dec_letter = 3'b010;
      {3'd1, 4'b0001}: dec_letter = 3'b011;
      {3'd3, 4'b0001}: dec_letter = 3'b100;
      {3'd4, 4'b0001}: dec_letter = 3'b101;
      {3'd3, 4'b0011}: dec_letter = 3'b110;
      {3'd4, 4'b1001}: dec_letter = 3'b111;
      default:         dec_ok     = 1'b0;
    endcase
  end

  // Outputs load on the edge that enters EMIT so they are already stable
  // during the letter_valid cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      letter     <= 3'b000;
      letter_err <= 1'b0;
    end else if (state == SPACE && state_next == EMIT) begin
      letter     <= (dec_ok && !err) ? dec_letter : 3'b000;
      letter_err <= !(dec_ok && !err);
    end
  end

  assign letter_valid = (state == EMIT);
  assign busy         = (state == MARK) || (state == SPACE);

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receiver stage for the Morse encoder's serial output. It samples the single-bit mark/space stream (LEDR drive), measures each high and low run in clock cycles, and classifies runs as dot, dash, symbol gap or letter gap. At each letter gap it decodes the collected pattern into the 3-bit SW letter code. It sits directly downstream of the encoder, so a selected letter can be looped back and checked on the board.

## Interface
- UNIT_CYCLES, 25000000: cycles per Morse unit (0.5 s at 50 MHz); benches use 10.
- GAP_UNITS, 3: low-run length, in units, that terminates a letter.
- CNT_W, 28: run-counter width; must hold 5*UNIT_CYCLES.
- CLOCK_50  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- morse_in  in  1  serial Morse; 1 = mark (LED on).
- letter  out  3  last decoded code, matching the SW encoding: Q=000, R=001, S=010, T=011, U=100, V=101, W=110, X=111.
- letter_valid  out  1  one-cycle pulse when letter/letter_err update.
- letter_err  out  1  last letter malformed or unmatched; valid alongside letter_valid, held until next pulse.
- busy  out  1  high while in MARK or SPACE.

## Operation
- 2-flop synchroniser on morse_in produces s; all decisions use s.
- Run counter: resets to 1 on any change of s, otherwise increments, saturating at 5*UNIT_CYCLES.
- Pattern register: 4 bits plus 3-bit symbol count. Symbols shift in MSB-first (1 = dash, 0 = dot). Sticky err flag.
- FSM states are IDLE, MARK, SPACE, EMIT.
  - IDLE: s=1 -> MARK, clear pattern, count and err.
  - MARK: s falls -> classify the run, -> SPACE. Run < 2*UNIT_CYCLES = dot. 2*UNIT_CYCLES to 4*UNIT_CYCLES inclusive = dash. Run > 4*UNIT_CYCLES sets err; no symbol is stored.
  - MARK, fifth symbol: if symbol count is already 4, set err and do not shift.
  - SPACE: s=1 -> MARK (symbol gap). Counter reaching GAP_UNITS*UNIT_CYCLES -> EMIT.
  - EMIT: pulse letter_valid, update letter and letter_err, -> IDLE.
- Decode table (length, bits):
  - Q: 4, 1101
  - R: 3, 010
  - S: 3, 000
  - T: 1, 1
  - U: 3, 001
  - V: 4, 0001
  - W: 3, 011
  - X: 4, 1001
- Any other pattern, or err set: letter=000, letter_err=1.
- Reset values: letter=000, letter_valid=0, letter_err=0, busy=0, FSM in IDLE, counters 0, synchroniser flops 0.
- Reset mid-letter discards the partial pattern; no letter_valid is produced.
- A stuck-high input stays in MARK (busy=1), the counter saturates, and no output is produced until s falls.
- A low stream in IDLE produces nothing.

## Timing
- Edge 0 is the first rising edge that samples morse_in=0 after the final mark.
- letter_valid is high for exactly the one cycle following edge GAP_UNITS*UNIT_CYCLES+2. With defaults, this is about 1.5 s after the LED goes off.
- The encoder's 1-unit inter-symbol gap (E state) is well below threshold. Its return to idle (E then A, ≥2 units low) ends the letter after 3 units.
- Mark classification takes effect on the edge where s is first seen 0.
- A new mark arriving in the same cycle as EMIT is ignored; the FSM enters IDLE and catches it on the next cycle. The encoder's minimum 1-unit low makes this unreachable in normal use.

## Test plan
All scenarios use UNIT_CYCLES=10 and GAP_UNITS=3.
- Q: high 30, low 10, high 30, low 10, high 10, low 10, high 30, then low. Required: a single letter_valid at edge 32 of the final low run, letter=000, letter_err=0, busy falls the same cycle.
- T, then S, separated by ≥40 low: high 30 gives letter=011. Three dots (high 10 / low 10) give letter=010. Exactly two valid pulses.
- Single dot (high 10, then low): letter_valid with letter=000 and letter_err=1 (E not in set). Five dots also give letter_err=1.
- Overlong mark (high 50, then low): letter_err=1 after the gap. The following valid letter X (high 30 / low 10 / high 10 / low 10 / high 10 / low 10 / high 30) gives letter=111 with letter_err cleared.
- Reset for 1 cycle after two dots, then hold low 60: no letter_valid, outputs stay 000/0/0, busy=0.
- Loopback with the encoder driving morse_in: for SW=0..7, each start press yields letter=SW and letter_err=0.
